// File: rtl/led_panel_scan_master.sv
// HUB75 scan/timing master: walks rows and bitplanes, generates the pixel read
// address, shift/latch/blank strobes and the front/back buffer select.
module led_panel_scan_master #(
    parameter int COLOR_BITS         = 8,
    parameter int DISPLAY_ROWS_LINES = 4,
    parameter int DISPLAY_COLS_LINES = 6,
    parameter int BASE_TICKS         = 8
) (
    input  logic                                         CLK,
    input  logic                                         RST,
    input  logic                                         enable,
    input  logic                                         swapReq,
    output logic                                         swapAck,
    output logic                                         frameStart,
    output logic [DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES-1:0] memAddrMst,
    output logic [2:0]                                   bitplaneMst,
    output logic                                         backbufferMst,
    output logic [DISPLAY_ROWS_LINES-1:0]                ADDR_MST,
    output logic                                         CLK_LED_MST,
    output logic                                         LATCH_MST,
    output logic                                         BLANK_MST
);

    localparam int RW = DISPLAY_ROWS_LINES;
    localparam int CW = DISPLAY_COLS_LINES;
    localparam logic [2:0]    LAST_PLANE = 3'(COLOR_BITS - 1);
    localparam logic [15:0]   BASE       = 16'(BASE_TICKS);
    localparam logic [CW-1:0] COL_ONE    = CW'(1);
    localparam logic [RW-1:0] ROW_ONE    = RW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t        state_reg;
    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [1:0]    phase_reg;
    logic [2:0]    plane_reg;
    logic          latch_cnt_reg;
    logic [15:0]   tick_reg;
    logic          pending_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            phase_reg     <= '0;
            plane_reg     <= '0;
            latch_cnt_reg <= 1'b0;
            tick_reg      <= '0;
            pending_reg   <= 1'b0;
            swapAck       <= 1'b0;
            frameStart    <= 1'b0;
            memAddrMst    <= '0;
            bitplaneMst   <= '0;
            backbufferMst <= 1'b0;
            ADDR_MST      <= '0;
            CLK_LED_MST   <= 1'b0;
            LATCH_MST     <= 1'b0;
            BLANK_MST     <= 1'b1;
        end else begin
            swapAck    <= 1'b0;
            frameStart <= 1'b0;
            // A frame-end swap below overrides this and consumes the request.
            if (swapReq) pending_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg   <= SHIFT;
                        row_reg     <= '0;
                        plane_reg   <= '0;
                        col_reg     <= '0;
                        phase_reg   <= '0;
                        memAddrMst  <= '0;
                        bitplaneMst <= '0;
                        frameStart  <= 1'b1;
                    end
                end

                SHIFT: begin
                    phase_reg <= phase_reg + 2'd1;
                    // Client RAM has one clock of read latency: rise two clocks after the address.
                    if (phase_reg == 2'd1) CLK_LED_MST <= 1'b1;
                    if (phase_reg == 2'd3) begin
                        CLK_LED_MST <= 1'b0;
                        if (&col_reg) begin
                            state_reg     <= LATCH;
                            LATCH_MST     <= 1'b1;
                            ADDR_MST      <= row_reg;
                            latch_cnt_reg <= 1'b0;
                        end else begin
                            col_reg    <= col_reg + COL_ONE;
                            memAddrMst <= {row_reg, col_reg + COL_ONE};
                        end
                    end
                end

                LATCH: begin
                    if (!latch_cnt_reg) begin
                        latch_cnt_reg <= 1'b1;
                    end else begin
                        state_reg <= DISPLAY;
                        LATCH_MST <= 1'b0;
                        BLANK_MST <= 1'b0;
                        tick_reg  <= (BASE << plane_reg) - 16'd1;
                    end
                end

                DISPLAY: begin
                    if (tick_reg != 16'd0) begin
                        tick_reg <= tick_reg - 16'd1;
                    end else begin
                        BLANK_MST <= 1'b1;
                        col_reg   <= '0;
                        phase_reg <= '0;
                        if (plane_reg != LAST_PLANE) begin
                            state_reg   <= SHIFT;
                            plane_reg   <= plane_reg + 3'd1;
                            bitplaneMst <= plane_reg + 3'd1;
                            memAddrMst  <= {row_reg, {CW{1'b0}}};
                        end else if (!(&row_reg)) begin
                            state_reg   <= SHIFT;
                            plane_reg   <= '0;
                            row_reg     <= row_reg + ROW_ONE;
                            bitplaneMst <= '0;
                            memAddrMst  <= {row_reg + ROW_ONE, {CW{1'b0}}};
                        end else begin
                            // Frame end: the only point where buffers swap and enable is honoured.
                            if (pending_reg || swapReq) begin
                                backbufferMst <= ~backbufferMst;
                                swapAck       <= 1'b1;
                                pending_reg   <= 1'b0;
                            end
                            row_reg     <= '0;
                            plane_reg   <= '0;
                            bitplaneMst <= '0;
                            memAddrMst  <= '0;
                            if (enable) begin
                                state_reg  <= SHIFT;
                                frameStart <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                                ADDR_MST  <= '0;
                            end
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_scan_master.sv
// Scoreboard bench for led_panel_scan_master on a reduced 4-row x 64-column,
// 8-plane geometry so that several whole frames fit in a short run.
module tb_led_panel_scan_master;

    localparam int CB    = 8;
    localparam int RL    = 2;
    localparam int CL    = 6;
    localparam int BT    = 2;
    localparam int NROWS = 1 << RL;
    localparam int NCOLS = 1 << CL;
    localparam int FRAME = NROWS * (CB * (4 * NCOLS + 2) + BT * ((1 << CB) - 1));

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            enable = 1'b0;
    logic            swapReq = 1'b0;
    logic            swapAck, frameStart, backbufferMst;
    logic [RL+CL-1:0] memAddrMst;
    logic [2:0]      bitplaneMst;
    logic [RL-1:0]   ADDR_MST;
    logic            CLK_LED_MST, LATCH_MST, BLANK_MST;

    int total = 0;
    int bad   = 0;

    led_panel_scan_master #(
        .COLOR_BITS(CB), .DISPLAY_ROWS_LINES(RL),
        .DISPLAY_COLS_LINES(CL), .BASE_TICKS(BT)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .swapReq(swapReq),
        .swapAck(swapAck), .frameStart(frameStart), .memAddrMst(memAddrMst),
        .bitplaneMst(bitplaneMst), .backbufferMst(backbufferMst),
        .ADDR_MST(ADDR_MST), .CLK_LED_MST(CLK_LED_MST),
        .LATCH_MST(LATCH_MST), .BLANK_MST(BLANK_MST)
    );

    always #5 CLK = ~CLK;

    typedef struct { int a; int b; } ev_t;
    ev_t ck_q[$];   // shift-clock rise: {address, clocks since address change}
    ev_t bl_q[$];   // blank-low pulse: {width, bitplane}
    ev_t la_q[$];   // latch pulse: {width, row address}
    ev_t sw_q[$];   // swapAck: {buffer after, buffer before}
    int  fs_q[$];   // frameStart cycle numbers

    int exp_addr[$];
    ev_t exp_bl[$];
    int exp_bb[$];

    // Output monitor, sampled on the falling edge.
    int unsigned cyc = 0;
    int since = 0, blank_w = 0, latch_w = 0, blank_plane = 0, latch_addr = 0;
    logic prev_clk = 1'b0, prev_blank = 1'b1, prev_latch = 1'b0, prev_bb = 1'b0;
    logic [RL+CL-1:0] prev_addr = '0;

    always @(negedge CLK) begin
        cyc++;
        if (frameStart === 1'b1) fs_q.push_back(int'(cyc));
        if (memAddrMst !== prev_addr || frameStart === 1'b1) since = 0;
        else since++;
        if (CLK_LED_MST === 1'b1 && prev_clk === 1'b0) ck_q.push_back('{int'(memAddrMst), since});
        if (BLANK_MST === 1'b0) begin
            if (prev_blank === 1'b1) blank_w = 0;
            blank_w++;
            blank_plane = int'(bitplaneMst);
        end else if (prev_blank === 1'b0) begin
            bl_q.push_back('{blank_w, blank_plane});
        end
        if (LATCH_MST === 1'b1) begin
            if (prev_latch === 1'b0) latch_w = 0;
            latch_w++;
            latch_addr = int'(ADDR_MST);
        end else if (prev_latch === 1'b1) begin
            la_q.push_back('{latch_w, latch_addr});
        end
        if (swapAck === 1'b1) sw_q.push_back('{int'(backbufferMst), int'(prev_bb)});
        prev_clk   = CLK_LED_MST;
        prev_blank = BLANK_MST;
        prev_latch = LATCH_MST;
        prev_bb    = backbufferMst;
        prev_addr  = memAddrMst;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [RL+CL+9:0] obs;
        int low_cnt;
        RST = 1'b1;
        enable = 1'b0;
        swapReq = 1'b0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        obs = {swapAck, frameStart, memAddrMst, bitplaneMst, backbufferMst,
               ADDR_MST, CLK_LED_MST, LATCH_MST};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        total++;
        if (BLANK_MST !== 1'b1) begin
            bad++;
            $display("FAIL reset_blank: got %b want 1", BLANK_MST);
        end
        ck_q.delete();
        sw_q.delete();
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            swapReq = (i == 500);
            tick();
            if (BLANK_MST !== 1'b1) low_cnt++;
        end
        swapReq = 1'b0;
        exp_bb.push_back(1);
        total++;
        if (ck_q.size() != 0 || low_cnt != 0) begin
            bad++;
            $display("FAIL idle_quiet: clk_edges=%0d blank_low=%0d want 0/0", ck_q.size(), low_cnt);
        end
        total++;
        if (sw_q.size() != 0) begin
            bad++;
            $display("FAIL idle_no_ack: acks=%0d want 0", sw_q.size());
        end
        $display("reset/idle: 1000 clocks idle, swap request left pending");
    endtask

    task automatic test_first_row();
        ev_t e;
        int want;
        bit got_latch;
        ck_q.delete();
        la_q.delete();
        enable = 1'b1;
        tick();
        total++;
        if (frameStart !== 1'b1 || memAddrMst !== '0 || bitplaneMst !== 3'd0) begin
            bad++;
            $display("FAIL first_frame_start: fs=%b addr=%h plane=%0d want 1/0/0",
                     frameStart, memAddrMst, bitplaneMst);
        end
        for (int c = 0; c < NCOLS; c++) exp_addr.push_back(c);
        for (int i = 0; i < 400 && exp_addr.size() > 0; i++) begin
            tick();
            while (ck_q.size() > 0 && exp_addr.size() > 0) begin
                e = ck_q.pop_front();
                want = exp_addr.pop_front();
                total++;
                if (e.a != want || e.b != 2) begin
                    bad++;
                    $display("FAIL shift_col: addr=%0h lag=%0d want addr=%0h lag=2", e.a, e.b, want);
                end
            end
        end
        total++;
        if (exp_addr.size() != 0) begin
            bad++;
            $display("FAIL shift_timeout: %0d columns missing, want 0", exp_addr.size());
            exp_addr.delete();
        end
        got_latch = 1'b0;
        for (int i = 0; i < 20 && !got_latch; i++) begin
            tick();
            if (la_q.size() > 0) begin
                got_latch = 1'b1;
                e = la_q.pop_front();
                total++;
                if (e.a != 2 || e.b != 0) begin
                    bad++;
                    $display("FAIL latch_row0: width=%0d addr=%0d want 2/0", e.a, e.b);
                end
                $display("latch: width=%0d addr=%0d", e.a, e.b);
            end
        end
        total++;
        if (!got_latch || ck_q.size() != 0) begin
            bad++;
            $display("FAIL latch_seen: latch=%0d extra_edges=%0d want 1/0", got_latch, ck_q.size());
        end
    endtask

    task automatic test_bitplanes();
        ev_t e, w;
        bit got_addr;
        for (int p = 0; p < CB; p++) exp_bl.push_back('{BT << p, p});
        for (int i = 0; i < 6000 && exp_bl.size() > 0; i++) begin
            tick();
            while (bl_q.size() > 0 && exp_bl.size() > 0) begin
                e = bl_q.pop_front();
                w = exp_bl.pop_front();
                total++;
                if (e.a != w.a || e.b != w.b) begin
                    bad++;
                    $display("FAIL plane_width: width=%0d plane=%0d want %0d/%0d", e.a, e.b, w.a, w.b);
                end
                $display("display: plane=%0d width=%0d", e.b, e.a);
                if (exp_bl.size() == 0) ck_q.delete();
            end
        end
        total++;
        if (exp_bl.size() != 0) begin
            bad++;
            $display("FAIL plane_timeout: %0d pulses missing, want 0", exp_bl.size());
            exp_bl.delete();
        end
        got_addr = 1'b0;
        for (int i = 0; i < 20 && !got_addr; i++) begin
            tick();
            if (ck_q.size() > 0) begin
                got_addr = 1'b1;
                e = ck_q.pop_front();
                total++;
                if (e.a != NCOLS) begin
                    bad++;
                    $display("FAIL row1_addr: addr=%0h want %0h", e.a, NCOLS);
                end
            end
        end
        total++;
        if (!got_addr) begin
            bad++;
            $display("FAIL row1_timeout: no shift edge, want one");
        end
    endtask

    task automatic test_frame_period();
        int t1;
        fs_q.delete();
        for (int i = 0; i < FRAME + 100 && fs_q.size() == 0; i++) tick();
        total++;
        if (fs_q.size() == 0) begin
            bad++;
            $display("FAIL frame_timeout1: no frameStart, want one");
            return;
        end
        t1 = fs_q[0];
        la_q.delete();
        for (int i = 0; i < FRAME + 100 && fs_q.size() < 2; i++) tick();
        total++;
        if (fs_q.size() < 2 || fs_q[1] - t1 != FRAME) begin
            bad++;
            $display("FAIL frame_period: starts=%0d period=%0d want %0d",
                     fs_q.size(), (fs_q.size() < 2) ? 0 : fs_q[1] - t1, FRAME);
            return;
        end
        $display("frame: period=%0d", fs_q[1] - t1);
        total++;
        if (la_q.size() != NROWS * CB || la_q[$].b != NROWS - 1) begin
            bad++;
            $display("FAIL last_row_latch: latches=%0d last=%0d want %0d/%0d",
                     la_q.size(), (la_q.size() > 0) ? la_q[$].b : -1, NROWS * CB, NROWS - 1);
        end
    endtask

    task automatic test_swap();
        bit seen;
        ev_t e;
        int want;
        repeat (100) tick();
        swapReq = 1'b1; tick(); swapReq = 1'b0;
        repeat (100) tick();
        swapReq = 1'b1; tick(); swapReq = 1'b0;
        exp_bb.push_back(0);
        seen = 1'b0;
        for (int i = 0; i < FRAME + 10 && !seen; i++) begin
            tick();
            seen = (frameStart === 1'b1);
        end
        total++;
        if (!seen || swapAck !== 1'b1 || backbufferMst !== 1'b0) begin
            bad++;
            $display("FAIL swap_double_req: seen=%0d ack=%b bb=%b want 1/1/0", seen, swapAck, backbufferMst);
        end
        // Request exactly on the final DISPLAY clock of this frame.
        repeat (FRAME - 1) tick();
        swapReq = 1'b1;
        total++;
        if (BLANK_MST !== 1'b0) begin
            bad++;
            $display("FAIL last_display_clk: blank=%b want 0", BLANK_MST);
        end
        exp_bb.push_back(1);
        tick();
        swapReq = 1'b0;
        total++;
        if (frameStart !== 1'b1 || swapAck !== 1'b1 || backbufferMst !== 1'b1) begin
            bad++;
            $display("FAIL swap_at_end: fs=%b ack=%b bb=%b want 1/1/1", frameStart, swapAck, backbufferMst);
        end
        tick();
        total++;
        if (sw_q.size() != exp_bb.size()) begin
            bad++;
            $display("FAIL swap_count: acks=%0d want %0d", sw_q.size(), exp_bb.size());
        end
        while (sw_q.size() > 0 && exp_bb.size() > 0) begin
            e = sw_q.pop_front();
            want = exp_bb.pop_front();
            total++;
            if (e.a != want || e.b != 1 - want) begin
                bad++;
                $display("FAIL swap_toggle: bb %0d->%0d want %0d->%0d", e.b, e.a, 1 - want, want);
            end
            $display("swap: bb %0d->%0d", e.b, e.a);
        end
    endtask

    task automatic test_reset_mid_and_enable_drop();
        logic [RL+CL+9:0] obs;
        int low_cnt;
        for (int i = 0; i < 3000 && BLANK_MST !== 1'b0; i++) tick();
        tick();
        RST = 1'b1;
        tick();
        obs = {swapAck, frameStart, memAddrMst, bitplaneMst, backbufferMst,
               ADDR_MST, CLK_LED_MST, LATCH_MST};
        total++;
        if (obs !== '0 || BLANK_MST !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: outs=%h blank=%b want 0/1", obs, BLANK_MST);
        end
        RST = 1'b0;
        tick();
        total++;
        if (frameStart !== 1'b1) begin
            bad++;
            $display("FAIL restart_after_reset: fs=%b want 1", frameStart);
        end
        // The frame just started must run to completion after enable drops.
        repeat (500) tick();
        enable = 1'b0;
        repeat (FRAME - 1 - 500) tick();
        total++;
        if (BLANK_MST !== 1'b0) begin
            bad++;
            $display("FAIL drain_last_display: blank=%b want 0", BLANK_MST);
        end
        tick();
        total++;
        if (frameStart !== 1'b0 || BLANK_MST !== 1'b1 || swapAck !== 1'b0 ||
            ADDR_MST !== '0 || memAddrMst !== '0) begin
            bad++;
            $display("FAIL enter_idle: fs=%b blank=%b ack=%b row=%0d addr=%h want 0/1/0/0/0",
                     frameStart, BLANK_MST, swapAck, ADDR_MST, memAddrMst);
        end
        ck_q.delete();
        low_cnt = 0;
        repeat (300) begin
            tick();
            if (BLANK_MST !== 1'b1) low_cnt++;
        end
        total++;
        if (ck_q.size() != 0 || low_cnt != 0) begin
            bad++;
            $display("FAIL idle_after_drain: edges=%0d blank_low=%0d want 0/0", ck_q.size(), low_cnt);
        end
        $display("enable drop: frame drained, idle");
    endtask

    initial begin
        test_reset();
        test_first_row();
        test_bitplanes();
        test_frame_period();
        test_swap();
        test_reset_mid_and_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_panel_scan_master.md
Name: led_panel_scan_master

Overview:
Scan/timing master for the HUB75-style 64x32 LED panel. It generates the column/row read address, the active bitplane, the front/back buffer select and the panel control strobes (ADDR, CLK_LED, LATCH, BLANK). One instance drives any number of LedPanelClient instances directly upstream, feeding their memAddrMst, bitplaneMst, backbufferMst, ADDR_MST, CLK_LED_MST, LATCH_MST and BLANK_MST inputs. Brightness uses binary-code modulation: bitplane b is displayed for BASE_TICKS<<b clocks.

Parameters:
COLOR_BITS, 8, bitplanes per colour; legal range 1..8.
DISPLAY_ROWS_LINES, 4, row address bits (16 scan rows, upper and lower halves in parallel).
DISPLAY_COLS_LINES, 6, column address bits (64 columns).
BASE_TICKS, 8, display clocks for bitplane 0; BASE_TICKS<<(COLOR_BITS-1) must be <= 65535.

Ports:
CLK  in  1  system clock (200 MHz)
RST  in  1  synchronous, active-high reset
enable  in  1  run scanning; sampled only at frame boundaries and in IDLE
swapReq  in  1  single-cycle request to exchange front and back buffers at the next frame end
swapAck  out  1  single-cycle pulse, coincident with the backbufferMst toggle
frameStart  out  1  single-cycle pulse on the first SHIFT cycle of row 0, bitplane 0
memAddrMst  out  DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES  {row, col} pixel read address to the clients
bitplaneMst  out  3  current bitplane, 0..COLOR_BITS-1
backbufferMst  out  1  buffer select; clients read !backbufferMst
ADDR_MST  out  DISPLAY_ROWS_LINES  panel row address (latched row)
CLK_LED_MST  out  1  panel shift clock
LATCH_MST  out  1  panel latch strobe
BLANK_MST  out  1  panel output blank (1 = dark)

Behaviour:
- All outputs are registered. Reset values: memAddrMst=0, bitplaneMst=0, backbufferMst=0, ADDR_MST=0, CLK_LED_MST=0, LATCH_MST=0, BLANK_MST=1, swapAck=0, frameStart=0. State = IDLE, row=0, col=0, plane=0, swap pending cleared.
- Reset asserted mid-operation takes effect on the next CLK edge, from any state.
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: outputs hold their reset values except backbufferMst, which retains its value. If enable=1, the next state is SHIFT with row=0 and plane=0.
- SHIFT: 4 clocks per column (phase 0..3), for a total of 4*2^DISPLAY_COLS_LINES clocks.
  - memAddrMst={row,col}, updated on phase 0.
  - CLK_LED_MST=1 in phases 2-3 only. The client memory has 1-clock read latency, so the rising edge falls 2 clocks after the address change.
  - BLANK_MST=1. ADDR_MST holds the previously latched row.
  - After col=max, phase 3: go to LATCH.
- LATCH: 2 clocks, LATCH_MST=1, BLANK_MST=1, CLK_LED_MST=0. ADDR_MST<=row on the first LATCH clock.
- DISPLAY: BLANK_MST=0 for exactly BASE_TICKS<<plane clocks, counted by a 16-bit down counter. On the last clock, advance:
  - plane increments; bitplaneMst stays constant across the SHIFT/LATCH/DISPLAY of one plane.
  - When plane=COLOR_BITS-1: plane<=0 and row increments.
  - When row=max as well: frame end.
  - Loop order is bitplane inner, row outer.
- Frame end:
  - If the swap is pending, or swapReq=1 on that same clock: toggle backbufferMst on the next edge, pulse swapAck for that one clock, clear pending.
  - Then, if enable=1, continue to SHIFT (row 0, plane 0, frameStart pulse); otherwise go to IDLE.
- swapReq at any other time sets pending. Repeated requests before a frame end collapse into one swap.
- With enable deasserted mid-frame, the current frame completes.
- Cycles per row-plane = 4*2^COLS + 2 + (BASE_TICKS<<b). With defaults, a frame is 16*(8*258 + 8*255) = 65664 clocks.

Test Plan:
- Reset with enable=0 -> BLANK_MST=1, all other outputs 0, no CLK_LED_MST edges for 1000 clocks; swapReq pulse stays pending with no swapAck.
- enable=1 after reset -> frameStart one clock after leaving IDLE; 64 CLK_LED_MST rising edges, each 2 clocks after a memAddrMst change; addresses 0x000..0x03F; then LATCH_MST=1 for exactly 2 clocks with ADDR_MST=0.
- Defaults, measure BLANK_MST=0 widths across row 0 -> 8,16,32,...,1024 clocks with bitplaneMst 0..7 respectively; next SHIFT uses memAddrMst row field=1.
- Free run -> frameStart period exactly 65664 clocks; last row latched has ADDR_MST=15.
- swapReq pulse mid-frame, and a second swapReq on the final DISPLAY clock of a later frame -> swapAck once per frame end, backbufferMst toggles 0->1->0; two requests within one frame give one toggle.
- RST asserted mid-DISPLAY, and enable dropped mid-frame -> reset values next clock; with enable low the frame completes, then the block enters IDLE with BLANK_MST=1.
